alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 19 +
 rtl/alu_sequencer_decode.sv | 18 +
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcode constants, opcode classes and sequencer states
package alu_sequencer_pkg;
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  typedef enum logic [1:0] {CLS_TWO, CLS_WIDE, CLS_ONE, CLS_ILLEGAL} op_cls_e;
  typedef enum logic [2:0] {S_IDLE, S_YLOAD, S_ZCAP, S_WBLO, S_WBHI, S_ERR} state_e;
endpackage

// File: rtl/alu_sequencer_decode.sv
// alu_op_decode: classifies an ALU opcode into two-operand, wide, one-operand or illegal
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [4:0] i_op_code,
  output op_cls_e    o_cls
);
  // opcode class lookup
  always_comb begin
    o_cls = CLS_ILLEGAL;
    case (i_op_code)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: o_cls = CLS_TWO;
      OP_MUL, OP_DIV: o_cls = CLS_WIDE;
      OP_NEG, OP_NOT: o_cls = CLS_ONE;
      default: o_cls = CLS_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps one ALU operation through Y load, Z capture and register write-back
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_clear,
  input  logic       i_start,
  input  logic [4:0] i_op_code,
  input  logic [3:0] i_ra,
  input  logic [3:0] i_rb,
  input  logic [3:0] i_rc,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_illegal,
  output logic [4:0] o_alu_op,
  output logic       o_reg_out_en,
  output logic [3:0] o_reg_out_sel,
  output logic       o_reg_in_en,
  output logic [3:0] o_reg_in_sel,
  output logic       o_y_in,
  output logic       o_z_in,
  output logic       o_zlo_out,
  output logic       o_zhi_out,
  output logic       o_lo_in,
  output logic       o_hi_in
);
  state_e     r_state;
  op_cls_e    r_cls;
  op_cls_e    w_cls;
  logic [4:0] r_op;
  logic [3:0] r_ra;
  logic [3:0] r_rc;
  logic       r_done;
  logic       r_illegal;
  logic [4:0] r_alu_op;
  logic       r_reg_out_en;
  logic [3:0] r_reg_out_sel;
  logic       r_reg_in_en;
  logic [3:0] r_reg_in_sel;
  logic       r_y_in;
  logic       r_z_in;
  logic       r_zlo_out;
  logic       r_zhi_out;
  logic       r_lo_in;
  logic       r_hi_in;

  alu_op_decode u_decode (
    .i_op_code(i_op_code),
    .o_cls    (w_cls)
  );

  // state and strobes are computed together so every output is a flop for the state being entered
  always_ff @(posedge i_clock) begin
    r_done        <= 1'b0;
    r_illegal     <= 1'b0;
    r_alu_op      <= OP_NOP;
    r_reg_out_en  <= 1'b0;
    r_reg_out_sel <= 4'd0;
    r_reg_in_en   <= 1'b0;
    r_reg_in_sel  <= 4'd0;
    r_y_in        <= 1'b0;
    r_z_in        <= 1'b0;
    r_zlo_out     <= 1'b0;
    r_zhi_out     <= 1'b0;
    r_lo_in       <= 1'b0;
    r_hi_in       <= 1'b0;
    if (i_clear) begin
      r_state <= S_IDLE;
      r_cls   <= CLS_TWO;
      r_op    <= OP_NOP;
      r_ra    <= 4'd0;
      r_rc    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op  <= i_op_code;
          r_ra  <= i_ra;
          r_rc  <= i_rc;
          r_cls <= w_cls;
          if (w_cls == CLS_ILLEGAL) begin
            r_state   <= S_ERR;
            r_illegal <= 1'b1;
          end else if (w_cls == CLS_ONE) begin
            r_state       <= S_ZCAP;
            r_reg_out_en  <= 1'b1;
            r_reg_out_sel <= i_rb;
            r_alu_op      <= i_op_code;
            r_z_in        <= 1'b1;
          end else begin
            r_state       <= S_YLOAD;
            r_reg_out_en  <= 1'b1;
            r_reg_out_sel <= i_rb;
            r_y_in        <= 1'b1;
          end
        end
        S_YLOAD: begin
          r_state       <= S_ZCAP;
          r_reg_out_en  <= 1'b1;
          r_reg_out_sel <= r_rc;
          r_alu_op      <= r_op;
          r_z_in        <= 1'b1;
        end
        S_ZCAP: begin
          r_state   <= S_WBLO;
          r_zlo_out <= 1'b1;
          if (r_cls == CLS_WIDE) begin
            r_lo_in <= 1'b1;
          end else begin
            r_reg_in_en  <= 1'b1;
            r_reg_in_sel <= r_ra;
            r_done       <= 1'b1;
          end
        end
        S_WBLO: if (r_cls == CLS_WIDE) begin
          r_state   <= S_WBHI;
          r_zhi_out <= 1'b1;
          r_hi_in   <= 1'b1;
          r_done    <= 1'b1;
        end else begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_state != S_IDLE;
  assign o_done        = r_done;
  assign o_illegal     = r_illegal;
  assign o_alu_op      = r_alu_op;
  assign o_reg_out_en  = r_reg_out_en;
  assign o_reg_out_sel = r_reg_out_sel;
  assign o_reg_in_en   = r_reg_in_en;
  assign o_reg_in_sel  = r_reg_in_sel;
  assign o_y_in        = r_y_in;
  assign o_z_in        = r_z_in;
  assign o_zlo_out     = r_zlo_out;
  assign o_zhi_out     = r_zhi_out;
  assign o_lo_in       = r_lo_in;
  assign o_hi_in       = r_hi_in;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench comparing every cycle of the sequencer outputs
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic [4:0] op = 5'd0;
  logic [3:0] ra = 4'd0, rb = 4'd0, rc = 4'd0;
  logic       busy, done, illegal, reg_out_en, reg_in_en, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
  logic [4:0] alu_op;
  logic [3:0] reg_out_sel, reg_in_sel;
  logic [23:0] obs;
  logic [23:0] q[$];
  int n_chk = 0;
  int n_pass = 0;
  localparam logic [5:0] Y = 6'b100000, Z = 6'b010000, ZL = 6'b001000, ZH = 6'b000100, LO = 6'b000010, HI = 6'b000001;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .i_clock      (clk),
    .i_clear      (clear),
    .i_start      (start),
    .i_op_code    (op),
    .i_ra         (ra),
    .i_rb         (rb),
    .i_rc         (rc),
    .o_busy       (busy),
    .o_done       (done),
    .o_illegal    (illegal),
    .o_alu_op     (alu_op),
    .o_reg_out_en (reg_out_en),
    .o_reg_out_sel(reg_out_sel),
    .o_reg_in_en  (reg_in_en),
    .o_reg_in_sel (reg_in_sel),
    .o_y_in       (y_in),
    .o_z_in       (z_in),
    .o_zlo_out    (zlo_out),
    .o_zhi_out    (zhi_out),
    .o_lo_in      (lo_in),
    .o_hi_in      (hi_in)
  );

  assign obs = {busy, done, illegal, alu_op, reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
                y_in, z_in, zlo_out, zhi_out, lo_in, hi_in};

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [23:0] v(input logic bsy, input logic dn, input logic il, input logic [4:0] a,
                                    input logic oe, input logic [3:0] os, input logic ie,
                                    input logic [3:0] is, input logic [5:0] st);
    return {bsy, dn, il, a, oe, os, ie, is, st};
  endfunction

  function automatic int cls(input logic [4:0] o);
    if (o >= 5'd3 && o <= 5'd11) return 0;
    if (o == 5'd15 || o == 5'd16) return 1;
    if (o == 5'd17 || o == 5'd18) return 2;
    return 3;
  endfunction

  task automatic push_seq(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, output int n);
    case (cls(o))
      0: begin
        q.push_back(v(1, 0, 0, 0, 1, b, 0, 0, Y));
        q.push_back(v(1, 0, 0, o, 1, c, 0, 0, Z));
        q.push_back(v(1, 1, 0, 0, 0, 0, 1, a, ZL));
        n = 3;
      end
      1: begin
        q.push_back(v(1, 0, 0, 0, 1, b, 0, 0, Y));
        q.push_back(v(1, 0, 0, o, 1, c, 0, 0, Z));
        q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, ZL | LO));
        q.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, ZH | HI));
        n = 4;
      end
      2: begin
        q.push_back(v(1, 0, 0, o, 1, b, 0, 0, Z));
        q.push_back(v(1, 1, 0, 0, 0, 0, 1, a, ZL));
        n = 2;
      end
      default: begin
        q.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 6'd0));
        n = 1;
      end
    endcase
    q.push_back(24'd0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check("one_driver", 24'(int'(reg_out_en) + int'(zlo_out) + int'(zhi_out) <= 1), 24'd1);
    if (q.size() > 0) check(tag, obs, q.pop_front());
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input bit poke);
    int n;
    start = 1'b1;
    op = o;
    ra = a;
    rb = b;
    rc = c;
    push_seq(o, a, b, c, n);
    step(tag);
    for (int i = 0; i < n; i++) begin
      start = poke;
      op = 5'($urandom_range(0, 31));
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 4'($urandom);
      step(tag);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [4:0] ops[6] = '{5'b00011, 5'b01111, 5'b10001, 5'b01100, 5'b10010, 5'b10000};
    for (int i = 0; i < 3; i++) begin
      q.push_back(24'd0);
      step("reset");
    end
    clear = 1'b0;
    q.push_back(24'd0);
    step("idle");
    run_op("add", 5'b00011, 4'd3, 4'd1, 4'd2, 1'b0);
    run_op("mul", 5'b01111, 4'd9, 4'd4, 4'd5, 1'b0);
    run_op("neg", 5'b10001, 4'd6, 4'd7, 4'd0, 1'b0);
    run_op("illegal", 5'b01100, 4'd1, 4'd2, 4'd3, 1'b0);
    run_op("add_poke", 5'b00011, 4'd3, 4'd1, 4'd2, 1'b1);
    run_op("div_poke", 5'b10000, 4'd8, 4'd10, 4'd11, 1'b1);
    start = 1'b1;
    op = 5'b00011;
    ra = 4'd3;
    rb = 4'd1;
    rc = 4'd2;
    q.push_back(v(1, 0, 0, 0, 1, 4'd1, 0, 0, Y));
    step("abort_y");
    start = 1'b0;
    q.push_back(v(1, 0, 0, 5'b00011, 1, 4'd2, 0, 0, Z));
    step("abort_z");
    clear = 1'b1;
    q.push_back(24'd0);
    step("abort_clear");
    clear = 1'b0;
    q.push_back(24'd0);
    step("abort_quiet");
    q.push_back(24'd0);
    step("abort_quiet");
    clear = 1'b1;
    start = 1'b1;
    q.push_back(24'd0);
    step("clear_prio");
    clear = 1'b0;
    start = 1'b0;
    q.push_back(24'd0);
    step("clear_prio");
    for (int k = 0; k < 6; k++) run_op("table", ops[k], 4'($urandom), 4'($urandom), 4'($urandom), k[0]);
    for (int k = 0; k < 24; k++)
      run_op("random", 5'($urandom_range(0, 31)), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    check("queue_drained", 24'(q.size()), 24'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
